// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Signal bundle between the boot image loader, the host byte
//               link and the instruction memory write port.
//               Byte link   : rx_valid / rx_data (in to loader), rx_ready (out)
//               Memory port : imem_we / imem_addr / imem_wdata (out)
//               Status      : cpu_hold / done / error (out)
//               slave  modport : the loader side
//               master modport : the host / memory / system side
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory writer. Receives a program image
//               as a byte stream (count lo/hi, N little-endian words, XOR
//               checksum byte), writes each assembled word to consecutive
//               word addresses and holds the CPU in reset until the image is
//               loaded and its checksum verified.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-high reset
//               bus   - imem_loader_if.slave (byte link, memory write port,
//                       cpu_hold / done / error status)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_cnt_lo;
    logic [15:0]       r_count;
    logic [IDX_W-1:0]  r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;      // first three bytes; the 4th goes straight out
    logic [7:0]        r_csum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_rx_ready;
    logic              w_accept;
    logic              w_last_word;
    logic [15:0]       w_hdr_count;

    assign w_hdr_count = {bus.rx_data, r_cnt_lo};
    assign w_last_word = ((16'(r_word_idx) + 16'd1) == r_count);

    // Ready is a pure state decode, additionally masked while reset is held
    // so nothing is offered as accepted before the loader is running.
    assign w_rx_ready = !reset && ((r_state == S_HDR_LO) || (r_state == S_HDR_HI) ||
                                   (r_state == S_DATA)   || (r_state == S_CHECK));
    assign w_accept   = bus.rx_valid && w_rx_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HDR_LO;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR_LO: begin
                if (w_accept) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (w_accept) begin
                    if (w_hdr_count == 16'd0)
                        w_next = S_CHECK;
                    else if (w_hdr_count > 16'(DEPTH))
                        w_next = S_ERROR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_next = (bus.rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: header capture, word assembly, checksum and write strobe.
    // Word index and checksum are only ever cleared by reset; a new load
    // always starts from reset so they begin at zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_lo   <= 8'd0;
            r_count    <= 16'd0;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
            r_csum     <= 8'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_HDR_LO: r_cnt_lo <= bus.rx_data;
                    S_HDR_HI: r_count  <= w_hdr_count;
                    S_DATA: begin
                        r_csum     <= r_csum ^ bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                r_we       <= 1'b1;
                                r_wdata    <= {bus.rx_data, r_word};
                                r_addr     <= ADDR_W'({r_word_idx, 2'b00});
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_hold   = (r_state != S_DONE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERROR);
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader. Bytes are
//               driven on the falling edge and outputs sampled on the falling
//               edge; a monitor logs every imem_we cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wbase;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH(8), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq_addr.push_back(bus.imem_addr);
            wq_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte starting at a falling edge; returns on the falling edge
    // after the rising edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("rx_accept_timeout", 64'd0, 64'd1);
            bus.rx_valid = 1'b0;
        end else begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic offer_ignored(input string tag, input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 4; i++) begin
            check(tag, 64'(bus.rx_ready), 64'd0);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                               input logic [31:0] d);
        if (wbase + idx < wq_addr.size()) begin
            check({tag, "_addr"}, 64'(wq_addr[wbase + idx]), 64'(a));
            check({tag, "_data"}, 64'(wq_data[wbase + idx]), 64'(d));
        end else begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
        check("rst_we",       64'(bus.imem_we),  64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_error",    64'(bus.error),    64'd0);
        reset = 1'b0;
        #1;
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        @(negedge clk);
        wbase = wq_addr.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        wbase        = 0;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // ---- 1: two words, good checksum ------------------------------------
        do_reset();
        check("rst_addr",  64'(bus.imem_addr),  64'd0);
        check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h20);
        check("t1_no_early_we", 64'(bus.imem_we), 64'd0);
        send_byte(8'h00);
        check("t1_w0_we",    64'(bus.imem_we),    64'd1);
        check("t1_w0_addr",  64'(bus.imem_addr),  64'h0);
        check("t1_w0_wdata", 64'(bus.imem_wdata), 64'h00200093);
        send_byte(8'h13);
        check("t1_we_one_cycle", 64'(bus.imem_we), 64'd0);
        send_byte(8'h01); send_byte(8'h90); send_byte(8'h00);
        check("t1_w1_we",    64'(bus.imem_we),    64'd1);
        check("t1_w1_addr",  64'(bus.imem_addr),  64'h4);
        check("t1_w1_wdata", 64'(bus.imem_wdata), 64'h00900113);
        check("t1_done_before_csum", 64'(bus.done), 64'd0);
        check("t1_hold_before_csum", 64'(bus.cpu_hold), 64'd1);
        send_byte(8'h31);
        check("t1_done",     64'(bus.done),     64'd1);
        check("t1_cpu_hold", 64'(bus.cpu_hold), 64'd0);
        check("t1_error",    64'(bus.error),    64'd0);
        offer_ignored("t1_ready_in_done", 8'h55);
        check("t1_write_count", 64'(wq_addr.size() - wbase), 64'd2);
        check_write("t1_wr0", 0, 32'h0, 32'h00200093);
        check_write("t1_wr1", 1, 32'h4, 32'h00900113);
        check("t1_done_sticky", 64'(bus.done), 64'd1);

        // ---- 2: empty image, good then bad checksum -------------------------
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t2a_done",        64'(bus.done), 64'd1);
        check("t2a_cpu_hold",    64'(bus.cpu_hold), 64'd0);
        check("t2a_write_count", 64'(wq_addr.size() - wbase), 64'd0);
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t2b_error",    64'(bus.error),    64'd1);
        check("t2b_done",     64'(bus.done),     64'd0);
        check("t2b_cpu_hold", 64'(bus.cpu_hold), 64'd1);

        // ---- 3: oversize header ---------------------------------------------
        do_reset();
        send_byte(8'h09); send_byte(8'h00);
        check("t3_error",    64'(bus.error),    64'd1);
        check("t3_rx_ready", 64'(bus.rx_ready), 64'd0);
        offer_ignored("t3_ready_in_error", 8'hAA);
        check("t3_write_count", 64'(wq_addr.size() - wbase), 64'd0);
        check("t3_error_sticky", 64'(bus.error), 64'd1);
        check("t3_cpu_hold", 64'(bus.cpu_hold), 64'd1);

        // ---- 3b: header exactly DEPTH is accepted into payload --------------
        do_reset();
        send_byte(8'h08); send_byte(8'h00);
        check("t3b_no_error", 64'(bus.error),    64'd0);
        check("t3b_ready",    64'(bus.rx_ready), 64'd1);

        // ---- 4: one word, bad checksum --------------------------------------
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h44332211);
        check("t4_we",    64'(bus.imem_we),    64'd1);
        check("t4_addr",  64'(bus.imem_addr),  64'h0);
        check("t4_wdata", 64'(bus.imem_wdata), 64'h44332211);
        send_byte(8'h00);
        check("t4_error",    64'(bus.error),    64'd1);
        check("t4_done",     64'(bus.done),     64'd0);
        check("t4_cpu_hold", 64'(bus.cpu_hold), 64'd1);

        // ---- 5: reset mid-load, then a fresh load ---------------------------
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h12345678);
        send_byte(8'hEF); send_byte(8'hBE);
        check("t5_pre_reset_writes", 64'(wq_addr.size() - wbase), 64'd1);
        check_write("t5_wr0", 0, 32'h0, 32'h12345678);
        do_reset();
        check("t5_no_write_after_reset", 64'(wq_addr.size() - wbase), 64'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEADBEEF);
        send_byte(8'h22);
        check("t5_done", 64'(bus.done), 64'd1);
        check("t5_write_count", 64'(wq_addr.size() - wbase), 64'd1);
        check_write("t5_wr_new", 0, 32'h0, 32'hDEADBEEF);

        // ---- 6: random gaps, then offers in DONE ----------------------------
        do_reset();
        send_gap(8'h03); send_gap(8'h00);
        send_gap(8'h04); send_gap(8'h03); send_gap(8'h02); send_gap(8'h01);
        send_gap(8'hA5); send_gap(8'hA5); send_gap(8'hA5); send_gap(8'hA5);
        send_gap(8'hFF); send_gap(8'hFF); send_gap(8'h00); send_gap(8'h00);
        send_gap(8'h04);
        check("t6_done",  64'(bus.done),  64'd1);
        check("t6_error", 64'(bus.error), 64'd0);
        offer_ignored("t6_ready_in_done", 8'h77);
        check("t6_write_count", 64'(wq_addr.size() - wbase), 64'd3);
        check_write("t6_wr0", 0, 32'h0, 32'h01020304);
        check_write("t6_wr1", 1, 32'h4, 32'hA5A5A5A5);
        check_write("t6_wr2", 2, 32'h8, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
